rv32i_register_file: RTL and testbench
======================================

Name: rv32i_register_file

Overview:
- 32-entry x 32-bit RV32I integer register file with one read port and one write port.
- Register x0 is hardwired to zero.
- Read and write are enable-qualified; each port returns a one-cycle-delayed valid strobe so a controller can handshake against it.
- Sits in the multicycle core datapath, between decode (source operand fetch) and writeback.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_rd_en  input  1  read request, sampled at the rising edge.
- i_reg_addr  input  5  read register index.
- o_reg_data  output  32  registered read data.
- i_wr_en  input  1  write request, sampled at the rising edge.
- i_dest_addr  input  5  write register index.
- i_dest_reg_data  input  32  write data.
- o_rd_valid  output  1  high for the cycle after each cycle that i_rd_en was sampled high.
- o_wr_valid  output  1  high for the cycle after each cycle that i_wr_en was sampled high.

Behaviour:
- Reset (i_rst low, asynchronous):
  - All 32 registers clear to 0.
  - o_reg_data = 0, o_rd_valid = 0, o_wr_valid = 0.
  - Outputs hold these values while i_rst is low.
  - Reset release is synchronised by the flops on the next rising edge; no operation is accepted while i_rst is low.
  - Reset mid-operation aborts any pending valid strobe.
- Write, rising edge with i_wr_en = 1:
  - regs[i_dest_addr] <= i_dest_reg_data, unless i_dest_addr = 0 (x0 write discarded).
  - o_wr_valid <= 1 regardless of address.
  - With i_wr_en = 0: o_wr_valid <= 0 and no register changes.
- Read, rising edge with i_rd_en = 1:
  - o_reg_data <= regs[i_reg_addr]; x0 always reads 0.
  - o_rd_valid <= 1.
  - Latency is 1 cycle: data and valid appear together after the sampling edge, and data is stable for the whole valid cycle.
- With i_rd_en = 0:
  - o_rd_valid <= 0.
  - o_reg_data holds its last value and is never cleared except by reset.
- Held enables:
  - Holding an enable high for N cycles performs N operations; the valid stays high for N consecutive cycles, one cycle delayed.
  - A new handshake is recognised by a fresh rising edge of the valid after the enable drops for at least one cycle.
- Simultaneous read and write, same cycle:
  - Both ports operate independently.
  - If i_reg_addr = i_dest_addr and it is nonzero, the read returns the new i_dest_reg_data (write-first bypass).
  - Both valids assert on the next cycle.
- Address range: every 5-bit index is legal; there is no out-of-range case.
- No combinational path from any input to any output; all outputs are flop outputs.

Test Plan:
- Reset: drive i_rst low mid-cycle -> o_reg_data, o_rd_valid, o_wr_valid go 0 immediately; reads of x1..x31 after release return 0x00000000.
- Write then read:
  - i_wr_en = 1, i_dest_addr = 5, data 0xDEADBEEF for one edge -> o_wr_valid = 1 the next cycle.
  - Then i_rd_en = 1, addr 5 -> o_rd_valid = 1 one cycle later with o_reg_data = 0xDEADBEEF.
- x0 protection: write 0x12345678 to addr 0 -> o_wr_valid still pulses; a subsequent read of addr 0 returns 0x00000000.
- Bypass: same edge write addr 7 = 0xA5A5A5A5 and read addr 7 (prior value 0) -> o_reg_data = 0xA5A5A5A5 with o_rd_valid = 1.
- Full sweep: write value (i * 0x01010101) to every register 1..31, then read all back -> each returns its value; x0 returns 0. Valids track enables with exactly 1-cycle delay.
- Hold/idle: hold i_rd_en high 3 cycles on addrs 1, 2, 3 -> o_rd_valid high for 3 cycles with data in order; drop i_rd_en -> o_rd_valid falls next cycle and o_reg_data holds the addr 3 value.

Source files
------------

// File: rtl/rv32i_register_file_if.sv
// Register-file port bundle: one read request/response pair and one write request/ack pair.
// The master side (decode/writeback controller) drives requests; the slave side is the register file.
interface rv32i_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  i_rd_en;
  logic [ADDR_WIDTH-1:0] i_reg_addr;
  logic [DATA_WIDTH-1:0] o_reg_data;
  logic                  i_wr_en;
  logic [ADDR_WIDTH-1:0] i_dest_addr;
  logic [DATA_WIDTH-1:0] i_dest_reg_data;
  logic                  o_rd_valid;
  logic                  o_wr_valid;

  modport master (
    output i_rd_en, i_reg_addr, i_wr_en, i_dest_addr, i_dest_reg_data,
    input  o_reg_data, o_rd_valid, o_wr_valid
  );

  modport slave (
    input  i_rd_en, i_reg_addr, i_wr_en, i_dest_addr, i_dest_reg_data,
    output o_reg_data, o_rd_valid, o_wr_valid
  );
endinterface

// File: rtl/rv32i_register_file.sv
// RV32I integer register file: 1 read + 1 write port, x0 hardwired to zero,
// registered read data with write-first bypass and one-cycle-delayed valid strobes.
module rv32i_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rv32i_register_file_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      wr_sel;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  rd_valid_q;
  logic                  wr_valid_q;
  logic                  bypass;

  // One-hot write decode; entry 0 is never selected so x0 stays at its reset value of zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      if (gi == 0) begin : g_x0
        assign wr_sel[gi] = 1'b0;
      end else begin : g_xn
        assign wr_sel[gi] = bus.i_wr_en && (bus.i_dest_addr == ADDR_WIDTH'(gi));
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs_q[i] <= bus.i_dest_reg_data;
        end
      end
    end
  end

  assign bypass = bus.i_wr_en && (bus.i_dest_addr == bus.i_reg_addr) &&
                  (bus.i_dest_addr != '0);

  // Same-edge read of the register being written returns the new data.
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.i_rd_en) begin
      rd_data_d = bypass ? bus.i_dest_reg_data : regs_q[bus.i_reg_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.i_rd_en;
      wr_valid_q <= bus.i_wr_en;
    end
  end

  assign bus.o_reg_data = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_wr_valid = wr_valid_q;
endmodule

// File: tb/tb_rv32i_register_file.sv
// Directed bench for rv32i_register_file: reset, write/read, x0, bypass, sweep, held enables.
module tb_rv32i_register_file;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rv32i_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  rv32i_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then return just after the next rising edge.
  task automatic cycle(input logic rd_en, input logic [4:0] raddr,
                       input logic wr_en, input logic [4:0] waddr, input logic [31:0] wdata);
    @(negedge clk);
    bus.i_rd_en         = rd_en;
    bus.i_reg_addr      = raddr;
    bus.i_wr_en         = wr_en;
    bus.i_dest_addr     = waddr;
    bus.i_dest_reg_data = wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.i_rd_en = 1'b0; bus.i_reg_addr = '0;
    bus.i_wr_en = 1'b0; bus.i_dest_addr = '0; bus.i_dest_reg_data = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_data", bus.o_reg_data, 32'h0);
    chk("reset_rd_valid", {31'd0, bus.o_rd_valid}, 32'd0);
    chk("reset_wr_valid", {31'd0, bus.o_wr_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    $display("write x5=deadbeef");
    chk("wr_valid_x5", {31'd0, bus.o_wr_valid}, 32'd1);
    chk("rd_valid_idle", {31'd0, bus.o_rd_valid}, 32'd0);

    cycle(1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
    $display("read x5 -> %h", bus.o_reg_data);
    chk("rd_valid_x5", {31'd0, bus.o_rd_valid}, 32'd1);
    chk("rd_data_x5", bus.o_reg_data, 32'hDEADBEEF);
    chk("wr_valid_drop", {31'd0, bus.o_wr_valid}, 32'd0);

    cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    $display("idle");
    chk("rd_valid_drop", {31'd0, bus.o_rd_valid}, 32'd0);
    chk("rd_data_hold", bus.o_reg_data, 32'hDEADBEEF);

    cycle(1'b0, 5'd0, 1'b1, 5'd0, 32'h12345678);
    $display("write x0=12345678");
    chk("wr_valid_x0", {31'd0, bus.o_wr_valid}, 32'd1);
    cycle(1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
    $display("read x0 -> %h", bus.o_reg_data);
    chk("rd_data_x0", bus.o_reg_data, 32'h0);
    chk("rd_valid_x0", {31'd0, bus.o_rd_valid}, 32'd1);

    cycle(1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5);
    $display("bypass rw x7 -> %h", bus.o_reg_data);
    chk("bypass_data", bus.o_reg_data, 32'hA5A5A5A5);
    chk("bypass_rd_valid", {31'd0, bus.o_rd_valid}, 32'd1);
    chk("bypass_wr_valid", {31'd0, bus.o_wr_valid}, 32'd1);
    cycle(1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    $display("read x7 -> %h", bus.o_reg_data);
    chk("x7_stored", bus.o_reg_data, 32'hA5A5A5A5);
    chk("x7_wr_valid_drop", {31'd0, bus.o_wr_valid}, 32'd0);

    for (int i = 1; i < 32; i++) begin
      v = i * 32'h01010101;
      cycle(1'b0, 5'd0, 1'b1, 5'(i), v);
      $display("sweep write x%0d=%h", i, v);
      chk("sweep_wr_valid", {31'd0, bus.o_wr_valid}, 32'd1);
    end
    for (int i = 0; i < 32; i++) begin
      v = i * 32'h01010101;
      cycle(1'b1, 5'(i), 1'b0, 5'd0, 32'h0);
      $display("sweep read x%0d -> %h", i, bus.o_reg_data);
      chk("sweep_rd_data", bus.o_reg_data, v);
      chk("sweep_rd_valid", {31'd0, bus.o_rd_valid}, 32'd1);
      if (i == 0) chk("sweep_wr_valid_drop", {31'd0, bus.o_wr_valid}, 32'd0);
    end

    cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    $display("idle");
    chk("idle_rd_valid", {31'd0, bus.o_rd_valid}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 5'(i), 1'b0, 5'd0, 32'h0);
      $display("hold read x%0d -> %h", i, bus.o_reg_data);
      chk("hold_rd_valid", {31'd0, bus.o_rd_valid}, 32'd1);
      chk("hold_rd_data", bus.o_reg_data, i * 32'h01010101);
    end
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    $display("hold drop");
    chk("hold_valid_fall", {31'd0, bus.o_rd_valid}, 32'd0);
    chk("hold_data_keep", bus.o_reg_data, 32'h03030303);

    cycle(1'b1, 5'd4, 1'b1, 5'd9, 32'hCAFEF00D);
    $display("rw before reset -> %h", bus.o_reg_data);
    chk("pre_rst_wr_valid", {31'd0, bus.o_wr_valid}, 32'd1);
    chk("pre_rst_data", bus.o_reg_data, 32'h04040404);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle");
    chk("midrst_data", bus.o_reg_data, 32'h0);
    chk("midrst_rd_valid", {31'd0, bus.o_rd_valid}, 32'd0);
    chk("midrst_wr_valid", {31'd0, bus.o_wr_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_wr_valid", {31'd0, bus.o_wr_valid}, 32'd0);
    chk("rst_hold_rd_valid", {31'd0, bus.o_rd_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      cycle(1'b1, 5'(i), 1'b0, 5'd0, 32'h0);
      $display("post-reset read x%0d -> %h", i, bus.o_reg_data);
      chk("post_rst_data", bus.o_reg_data, 32'h0);
    end
    chk("post_rst_rd_valid", {31'd0, bus.o_rd_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
